// File: rtl/vmul_seq_ctrl_if.sv
// Request, response, flush and multiplier-array signals of vmul_seq_ctrl.
// The slave modport is the sequencer; the master modport is the requester/array side.
interface vmul_seq_ctrl_if;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_sew;
   logic [31:0]   req_a1;
   logic [31:0]   req_b1;
   logic [31:0]   req_a2;
   logic [31:0]   req_b2;

   logic          resp_valid;
   logic          resp_ready;
   logic [127:0]  resp_res;
   logic          resp_err;

   logic          flush;

   logic          mul_go;
   logic [1:0]    mul_sew;
   logic          mul_count_0;
   logic [31:0]   mul_a1;
   logic [31:0]   mul_b1;
   logic [31:0]   mul_a2;
   logic [31:0]   mul_b2;
   logic [63:0]   mul_res_i;

   logic          busy;

   modport slave (
      input  req_valid, req_sew, req_a1, req_b1, req_a2, req_b2,
      input  resp_ready, flush, mul_res_i,
      output req_ready, resp_valid, resp_res, resp_err,
      output mul_go, mul_sew, mul_count_0, mul_a1, mul_b1, mul_a2, mul_b2,
      output busy
   );

   modport master (
      output req_valid, req_sew, req_a1, req_b1, req_a2, req_b2,
      output resp_ready, flush, mul_res_i,
      input  req_ready, resp_valid, resp_res, resp_err,
      input  mul_go, mul_sew, mul_count_0, mul_a1, mul_b1, mul_a2, mul_b2,
      input  busy
   );
endinterface

// File: rtl/vmul_seq_ctrl.sv
// Sequencer driving an 8-bit multiplier array for one or two passes per request.
// Optional macro VMUL_SEQ_SEW_ERR_EN: reject sew=11 with resp_err instead of running two passes.
module vmul_seq_ctrl #(
   parameter int MUL_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   vmul_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [1:0]    r_mul_sew;
   logic          r_count_0;
   logic          r_two_pass;
   logic [31:0]   r_a1;
   logic [31:0]   r_b1;
   logic [31:0]   r_a2;
   logic [31:0]   r_b2;
   logic [2:0]    r_lat_cnt;
   logic [63:0]   r_res_lo;
   logic [63:0]   r_res_hi;

   logic          w_accept;
   logic          w_capture;
   logic          w_sew_err;

   assign w_accept  = (r_state == IDLE) && bus.req_valid && !bus.flush;
   assign w_capture = (r_state == WAIT) && (r_lat_cnt == 3'd1);

`ifdef VMUL_SEQ_SEW_ERR_EN
   logic          r_err;

   assign w_sew_err    = (bus.req_sew == 2'b11);
   assign bus.resp_err = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (bus.flush) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= w_sew_err;
      end
   end
`else
   assign w_sew_err    = 1'b0;
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next = w_sew_err ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            w_state_next = WAIT;
         end
         WAIT: begin
            // A two-pass request loops back for its upper half after pass 0.
            if (w_capture) begin
               w_state_next = (r_two_pass && !r_count_0) ? ISSUE : DONE;
            end
         end
         DONE: begin
            if (bus.resp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      if (bus.flush) begin
         w_state_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mul_sew  <= 2'b00;
         r_count_0  <= 1'b0;
         r_two_pass <= 1'b0;
         r_a1       <= 32'h0;
         r_b1       <= 32'h0;
         r_a2       <= 32'h0;
         r_b2       <= 32'h0;
         r_lat_cnt  <= 3'd0;
         r_res_lo   <= 64'h0;
         r_res_hi   <= 64'h0;
      end else if (bus.flush) begin
         r_count_0  <= 1'b0;
         r_lat_cnt  <= 3'd0;
         r_res_lo   <= 64'h0;
         r_res_hi   <= 64'h0;
      end else begin
         if (w_accept) begin
            r_mul_sew  <= bus.req_sew;
            r_two_pass <= bus.req_sew[1];
            r_a1       <= bus.req_a1;
            r_b1       <= bus.req_b1;
            r_a2       <= bus.req_a2;
            r_b2       <= bus.req_b2;
            r_count_0  <= 1'b0;
            r_res_lo   <= 64'h0;
            r_res_hi   <= 64'h0;
         end

         if (r_state == ISSUE) begin
            r_lat_cnt <= 3'(MUL_LAT);
         end else if ((r_state == WAIT) && (r_lat_cnt != 3'd0)) begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
         end

         // mul_res_i is only trusted on the last WAIT cycle of each pass.
         if (w_capture) begin
            if (r_count_0) begin
               r_res_hi <= bus.mul_res_i;
            end else begin
               r_res_lo <= bus.mul_res_i;
            end
            if (r_two_pass && !r_count_0) begin
               r_count_0 <= 1'b1;
            end
         end
      end
   end

   assign bus.req_ready   = (r_state == IDLE) && !bus.flush;
   assign bus.mul_go      = (r_state == ISSUE);
   assign bus.busy        = (r_state != IDLE);
   assign bus.resp_valid  = (r_state == DONE);
   assign bus.resp_res    = {r_res_hi, r_res_lo};
   assign bus.mul_sew     = r_mul_sew;
   assign bus.mul_count_0 = r_count_0;
   assign bus.mul_a1      = r_a1;
   assign bus.mul_b1      = r_b1;
   assign bus.mul_a2      = r_a2;
   assign bus.mul_b2      = r_b2;

endmodule

// File: tb/tb_vmul_seq_ctrl.sv
// Self-checking bench for vmul_seq_ctrl: vector table, corner sequences, random run vs. reference model.
module tb_vmul_seq_ctrl;

   localparam int LAT = 1;

   bit   clk;
   logic reset;

   vmul_seq_ctrl_if bus ();

   vmul_seq_ctrl #(.MUL_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   n_cmp = 0;
   int   n_bad = 0;
   logic stub_fixed = 1'b1;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, got, exp);
      end
   endtask

   task automatic chki(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, exp);
      end
   endtask

   // Behavioural multiplier array: fixed A0/B1 pattern or lane products of the operands.
   function automatic logic [63:0] stub_val(input logic [31:0] a1, b1, a2, b2, input logic c0);
      logic [31:0] p_hi;
      logic [31:0] p_lo;
      if (stub_fixed) begin
         return c0 ? 64'hB1 : 64'hA0;
      end
      p_hi = c0 ? a1 * b2 : a1 * b1;
      p_lo = c0 ? a2 * b1 : a2 * b2;
      return {p_hi, p_lo};
   endfunction

   // Array stub: valid data only on the LAT-th cycle after a go pulse, junk otherwise.
   int          stub_age = 0;
   logic        stub_pend = 1'b0;
   logic [31:0] s_a1, s_b1, s_a2, s_b2;
   logic        s_c0;
   always @(negedge clk) begin
      if (!reset) begin
         stub_pend = 1'b0;
      end else if (bus.mul_go) begin
         stub_pend = 1'b1;
         stub_age  = 0;
         s_a1 = bus.mul_a1; s_b1 = bus.mul_b1; s_a2 = bus.mul_a2; s_b2 = bus.mul_b2;
         s_c0 = bus.mul_count_0;
      end else if (stub_pend) begin
         stub_age++;
      end
      if (stub_pend && stub_age == LAT) begin
         bus.mul_res_i = stub_val(s_a1, s_b1, s_a2, s_b2, s_c0);
         stub_pend     = 1'b0;
      end else begin
         bus.mul_res_i = {$urandom, $urandom};
      end
   end

   int   go_total = 0;
   logic c0_q[$];
   always @(negedge clk) begin
      if (reset && bus.mul_go) begin
         go_total++;
         c0_q.push_back(bus.mul_count_0);
      end
   end

   // Reference: pass count and latency follow from sew alone; result is the stacked pass outputs.
   function automatic void model(input logic [1:0] sew, input logic [31:0] a1, b1, a2, b2,
                                 output int lat, output logic [127:0] res, output logic err,
                                 output int gos, output logic [1:0] c0);
      int passes;
      passes = (sew >= 2'd2) ? 2 : 1;
`ifdef VMUL_SEQ_SEW_ERR_EN
      if (sew == 2'b11) passes = 0;
`endif
      lat = (passes == 0) ? 1 : (passes == 1) ? 2 + LAT : 3 + 2 * LAT;
      res = '0;
      for (int p = 0; p < passes; p++) begin
         res[64*p +: 64] = stub_val(a1, b1, a2, b2, p[0]);
      end
      err = (passes == 0);
      gos = passes;
      c0  = (passes == 2) ? 2'b10 : 2'b00;
   endfunction

   task automatic do_txn(input int id, input logic [1:0] sew, input logic [31:0] a1, b1, a2, b2,
                         input int flush_at, input int hold, input int exp_lat,
                         input logic [127:0] exp_res, input logic exp_err, input int exp_gos,
                         input logic [1:0] exp_c0);
      int          lat;
      int          go0;
      int          spur;
      logic        acc;
      logic        done;
      logic        stable;
      logic [127:0] res;
      logic        err;
      logic [1:0]  c0;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_sew   = sew;
      bus.req_a1 = a1; bus.req_b1 = b1; bus.req_a2 = a2; bus.req_b2 = b2;
      go0 = go_total;
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
         @(negedge clk);
         acc = bus.req_ready;
      end
      chk1("accept", acc, 1'b1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_sew   = 2'($urandom);
      bus.req_a1 = $urandom; bus.req_b1 = $urandom; bus.req_a2 = $urandom; bus.req_b2 = $urandom;
      if (!acc) return;
      lat  = 0;
      done = 1'b0;
      res  = '0;
      err  = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         if (k == flush_at) bus.flush = 1'b1;
         @(negedge clk);
         if (k == 1) chki("mul_sew", int'(bus.mul_sew), int'(sew));
         if (k == flush_at) chk1("flush_no_ready", bus.req_ready, 1'b0);
         if (bus.resp_valid) begin
            lat  = k;
            res  = bus.resp_res;
            err  = bus.resp_err;
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
            if (k == flush_at) begin
               bus.flush = 1'b0;
               done      = 1'b1;
            end
         end
      end
      if (flush_at > 0) begin
         chki("resp_before_flush", lat, 0);
         @(negedge clk);
         chk1("flush_idle", bus.busy, 1'b0);
         spur = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.resp_valid) spur++;
         end
         chki("flush_no_resp", spur, 0);
         $display("txn %0d sew=%0d flushed at cycle %0d", id, sew, flush_at);
      end else begin
         c0 = 2'b00;
         for (int p = 0; p < 2; p++) begin
            if (go0 + p < c0_q.size()) c0[p] = c0_q[go0 + p];
         end
         chki("latency", lat, exp_lat);
         chk("resp_res", res, exp_res);
         chk1("resp_err", err, exp_err);
         chki("go_pulses", go_total - go0, exp_gos);
         chki("count_0_seq", int'(c0), int'(exp_c0));
         if (lat > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               if (!bus.resp_valid || bus.resp_res !== res || bus.resp_err !== err || bus.req_ready)
                  stable = 1'b0;
            end
            if (hold > 0) chk1("hold_stable", stable, 1'b1);
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
            @(negedge clk);
            chk1("release_valid", bus.resp_valid, 1'b0);
            chk1("release_ready", bus.req_ready, 1'b1);
         end
         $display("txn %0d sew=%0d lat=%0d res=%h err=%0b hold=%0d", id, sew, lat, res, err, hold);
      end
   endtask

   typedef struct {
      logic [1:0]   sew;
      int           flush_at;
      int           hold;
      int           exp_lat;
      logic [127:0] exp_res;
      logic         exp_err;
      int           exp_gos;
      logic [1:0]   exp_c0;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          gos;
      int          fa;
      int          go0;
      int          spur;
      logic [127:0] res;
      logic        err;
      logic [1:0]  c0;
      logic [1:0]  sew;
      logic [31:0] a1, b1, a2, b2;
      logic        any;

      vecs[0] = '{2'b00, 0, 0, 3, 128'hA0, 1'b0, 1, 2'b00};
      vecs[1] = '{2'b01, 0, 1, 3, 128'hA0, 1'b0, 1, 2'b00};
      vecs[2] = '{2'b10, 0, 0, 5, {64'hB1, 64'hA0}, 1'b0, 2, 2'b10};
      vecs[3] = '{2'b00, 0, 4, 3, 128'hA0, 1'b0, 1, 2'b00};
      vecs[4] = '{2'b10, 2, 0, 0, 128'h0, 1'b0, 0, 2'b00};
      vecs[5] = '{2'b10, 4, 0, 0, 128'h0, 1'b0, 0, 2'b00};
      vecs[6] = '{2'b00, 1, 0, 0, 128'h0, 1'b0, 0, 2'b00};
`ifdef VMUL_SEQ_SEW_ERR_EN
      vecs[7] = '{2'b11, 0, 2, 1, 128'h0, 1'b1, 0, 2'b00};
`else
      vecs[7] = '{2'b11, 0, 2, 5, {64'hB1, 64'hA0}, 1'b0, 2, 2'b10};
`endif

      reset          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_sew    = 2'b00;
      bus.req_a1 = 32'h0; bus.req_b1 = 32'h0; bus.req_a2 = 32'h0; bus.req_b2 = 32'h0;
      bus.resp_ready = 1'b0;
      bus.flush      = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      any = bus.busy | bus.resp_valid | bus.mul_go | bus.mul_count_0 | (|bus.resp_res)
            | (|bus.mul_a1) | (|bus.mul_b2) | (|bus.mul_sew);
      chk1("reset_state_zero", any, 1'b0);
      #1 reset = 1'b1;
      @(negedge clk);
      chk1("ready_after_reset", bus.req_ready, 1'b1);

      stub_fixed = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_txn(i, vecs[i].sew, $urandom, $urandom, $urandom, $urandom, vecs[i].flush_at,
                vecs[i].hold, vecs[i].exp_lat, vecs[i].exp_res, vecs[i].exp_err,
                vecs[i].exp_gos, vecs[i].exp_c0);
      end

      // flush in IDLE must block acceptance even with req_valid high
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_sew   = 2'b00;
      bus.flush     = 1'b1;
      @(negedge clk);
      chk1("idle_flush_ready", bus.req_ready, 1'b0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      @(negedge clk);
      chk1("idle_flush_no_accept", bus.busy, 1'b0);
      $display("txn idle-flush busy=%0b", bus.busy);

      // reset asserted while the request sits in ISSUE
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_sew   = 2'b10;
      bus.req_a1 = 32'h1234_5678; bus.req_b1 = 32'h9ABC_DEF0;
      bus.req_a2 = 32'h0F0F_0F0F; bus.req_b2 = 32'hF0F0_F0F0;
      @(negedge clk);
      chk1("rst_test_ready", bus.req_ready, 1'b1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk1("rst_test_in_issue", bus.mul_go, 1'b1);
      #1 reset = 1'b0;
      #1;
      any = bus.busy | bus.resp_valid | bus.mul_go | bus.mul_count_0 | bus.resp_err
            | (|bus.resp_res) | (|bus.mul_sew)
            | (|bus.mul_a1) | (|bus.mul_b1) | (|bus.mul_a2) | (|bus.mul_b2);
      chk1("rst_outputs_zero", any, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      go0 = go_total;
      @(negedge clk);
      chk1("rst_release_ready", bus.req_ready, 1'b1);
      spur = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.resp_valid || bus.busy) spur++;
      end
      chki("rst_no_resp", spur, 0);
      chki("rst_no_go", go_total - go0, 0);
      $display("txn reset-in-issue spurious=%0d", spur);

      stub_fixed = 1'b0;
      for (int i = 0; i < 30; i++) begin
         sew = 2'($urandom_range(0, 3));
         a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
         model(sew, a1, b1, a2, b2, lat, res, err, gos, c0);
         fa = 0;
         if (lat > 1 && $urandom_range(0, 5) == 0) fa = $urandom_range(1, lat - 1);
         do_txn(100 + i, sew, a1, b1, a2, b2, fa, $urandom_range(0, 3), lat, res, err, gos, c0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vmul_seq_ctrl.md
VMUL_SEQ_CTRL -- requirements
Module: vmul_seq_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 1, range 1..7: cycles from a multiplier pass issue to a valid mul_res_i.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_sew (in, 2), req_a1, req_b1, req_a2, req_b2 (in, 32 each): request channel.
REQ-005 SHALL have ports resp_valid (out, 1), resp_ready (in, 1), resp_res (out, 128), resp_err (out, 1): response channel.
REQ-006 SHALL have port flush (in, 1): synchronous abort of any in-flight request.
REQ-007 SHALL have ports mul_go (out, 1), mul_sew (out, 2), mul_count_0 (out, 1), mul_a1, mul_b1, mul_a2, mul_b2 (out, 32 each): 8-bit multiplier array control and operands.
REQ-008 SHALL have ports mul_res_i (in, 64) for the array pass result and busy (out, 1), high whenever state is not IDLE.

Function
REQ-009 SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-010 SHALL drive req_ready=1 only in IDLE with flush=0; acceptance is req_valid&req_ready at a rising edge.
REQ-011 SHALL, on acceptance, register req_sew and the four operands into mul_sew/mul_a*/mul_b*, clear mul_count_0, and move to ISSUE.
REQ-012 SHALL hold mul_sew, mul_count_0 and mul_a*/mul_b* stable from ISSUE until capture.
REQ-013 SHALL, in ISSUE, assert mul_go for exactly one cycle, then enter WAIT with a latency counter loaded to MUL_LAT.
REQ-014 SHALL capture mul_res_i at the end of the MUL_LAT-th cycle after the ISSUE cycle: pass 0 into res[63:0], pass 1 into res[127:64].
REQ-015 SHALL set the pass count to 1 for sew=00 and 01 and to 2 for sew=10; after pass 0 of a sew=10 request, set mul_count_0=1 and return to ISSUE.
REQ-016 SHALL, after the final capture, enter DONE with resp_valid=1; single-pass resp_res={64'h0,pass0}; two-pass resp_res={pass1,pass0}.
REQ-017 SHALL make resp_valid first visible 2+MUL_LAT cycles after the acceptance cycle for single-pass requests and 3+2*MUL_LAT cycles for two-pass requests.
REQ-018 SHALL hold resp_valid, resp_res and resp_err stable in DONE until resp_ready=1, then return to IDLE on that edge.
REQ-019 SHALL accept the next request no earlier than the cycle after the DONE-to-IDLE transition.
REQ-020 SHALL, when flush=1 in any state, return to IDLE on the next edge, drop resp_valid, discard captured results and produce no response; flush overrides resp_ready and req_valid.
REQ-021 SHALL leave the request outstanding when mul_res_i changes outside its capture cycle, and ignore those changes.

Reset
REQ-022 SHALL, while reset=0, force state=IDLE, mul_go=0, mul_count_0=0, mul_sew=0, all mul_a*/mul_b*=0, resp_valid=0, resp_err=0, resp_res=0, the latency counter to 0 and busy=0, regardless of clk.
REQ-023 SHALL discard any in-flight request when reset asserts mid-operation and emit no response for it after release.
REQ-024 SHALL make req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL gate illegal-SEW checking with macro VMUL_SEQ_SEW_ERR_EN.
REQ-026 SHALL, with VMUL_SEQ_SEW_ERR_EN defined, go directly from acceptance of req_sew=11 to DONE with resp_err=1, resp_res=0 and no mul_go pulses; resp_valid is visible 1 cycle after acceptance.
REQ-027 SHALL, with VMUL_SEQ_SEW_ERR_EN undefined, tie resp_err to 0 and treat req_sew=11 as sew=10 (two passes).

Verification
REQ-028 SHALL cover sew=00, MUL_LAT=1, stub drives mul_res_i=64'hA0 -> one mul_go pulse, resp_valid 3 cycles after acceptance, resp_res=128'hA0.
REQ-029 SHALL cover sew=10, stub drives 64'hA0 on count_0=0 and 64'hB1 on count_0=1 -> two mul_go pulses, mul_count_0 0 then 1, resp_res={64'hB1,64'hA0} at cycle 5.
REQ-030 SHALL cover resp_ready held 0 for 4 cycles after resp_valid -> resp_valid and resp_res stable, req_ready=0 throughout.
REQ-031 SHALL cover flush pulsed during WAIT of a sew=10 request -> IDLE next cycle, no resp_valid, next request completes normally.
REQ-032 SHALL cover reset asserted during ISSUE -> all outputs 0 immediately, req_ready=1 in the first cycle after release.
REQ-033 SHALL cover req_sew=11 -> with macro defined: resp_err=1, resp_res=0, no mul_go; without the macro: a two-pass result.
